// File: rtl/cfglut5_reconfig_ctrl.sv
// CFGLUT5 chain reconfiguration sequencer: shifts a new chain image in
// MSB-first under CE gating and captures the displaced image from the tail.
module cfglut5_reconfig_ctrl #(
  parameter int NUM_LUTS = 1
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic [32*NUM_LUTS-1:0] REQ_DATA,
  input  logic                   PAUSE,
  output logic                   LUT_CE,
  output logic                   LUT_CDI,
  input  logic                   LUT_CDO,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [32*NUM_LUTS-1:0] RDBK_DATA
);

  localparam int L  = 32 * NUM_LUTS;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SHIFT  = 3'b010,
    S_FINISH = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [L-1:0]  shreg_q, shreg_d;
  logic [L-1:0]  cap_q, cap_d;
  logic [L-1:0]  rdbk_q, rdbk_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic advance;
  logic last;

  assign accept  = (state_q == S_IDLE) && REQ_VALID;
  assign advance = (state_q == S_SHIFT) && !PAUSE;
  assign last    = advance && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Readback is committed on the final shift so it is valid with DONE.
  always_comb begin
    shreg_d = shreg_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    rdbk_d  = rdbk_q;
    if (accept) begin
      shreg_d = REQ_DATA;
      cnt_d   = '0;
    end
    if (advance) begin
      shreg_d = {shreg_q[L-2:0], 1'b0};
      cap_d   = {cap_q[L-2:0], LUT_CDO};
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
    if (last) begin
      rdbk_d = cap_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      shreg_q <= '0;
      cap_q   <= '0;
      rdbk_q  <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cap_q   <= cap_d;
      rdbk_q  <= rdbk_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    REQ_READY = 1'b0;
    LUT_CE    = 1'b0;
    LUT_CDI   = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
      end
      S_SHIFT: begin
        BUSY    = 1'b1;
        LUT_CE  = !PAUSE;
        LUT_CDI = shreg_q[L-1];
      end
      S_FINISH: begin
        DONE = 1'b1;
      end
      default: begin
        REQ_READY = 1'b0;
      end
    endcase
  end

  assign RDBK_DATA = rdbk_q;

endmodule

// File: tb/tb_cfglut5_reconfig_ctrl.sv
// Bench for cfglut5_reconfig_ctrl: one- and two-LUT chains driving
// behavioural CFGLUT5 shift models, table-driven plus random loads.
module tb_cfglut5_reconfig_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        pause     [2];
  logic        ce        [2];
  logic        cdi       [2];
  logic        cdo       [2];
  logic        busy      [2];
  logic        done      [2];
  logic [63:0] req_data  [2];
  logic [31:0] rdbk0;
  logic [63:0] rdbk1;

  logic [31:0] lut0  = '0;
  logic [31:0] lut1h = '0;
  logic [31:0] lut1t = '0;

  cfglut5_reconfig_ctrl #(.NUM_LUTS(1)) u0 (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_DATA(req_data[0][31:0]), .PAUSE(pause[0]),
    .LUT_CE(ce[0]), .LUT_CDI(cdi[0]), .LUT_CDO(cdo[0]),
    .BUSY(busy[0]), .DONE(done[0]), .RDBK_DATA(rdbk0)
  );

  cfglut5_reconfig_ctrl #(.NUM_LUTS(2)) u1 (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_DATA(req_data[1]), .PAUSE(pause[1]),
    .LUT_CE(ce[1]), .LUT_CDI(cdi[1]), .LUT_CDO(cdo[1]),
    .BUSY(busy[1]), .DONE(done[1]), .RDBK_DATA(rdbk1)
  );

  // CFGLUT5 model: r shifts left on CE, CDI into r[0], CDO = r[31].
  assign cdo[0] = lut0[31];
  assign cdo[1] = lut1t[31];

  always @(posedge clk) begin
    if (ce[0]) lut0 <= {lut0[30:0], cdi[0]};
    if (ce[1]) begin
      lut1h <= {lut1h[30:0], cdi[1]};
      lut1t <= {lut1t[30:0], lut1h[31]};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_chain [2];

  function automatic int len(input int s);
    return 32 * (s + 1);
  endfunction

  function automatic logic [63:0] msk(input int s);
    return (s == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] chain(input int s);
    return (s == 1) ? {lut1t, lut1h} : {32'h0, lut0};
  endfunction

  function automatic logic [63:0] rdbk(input int s);
    return (s == 1) ? rdbk1 : {32'h0, rdbk0};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int s, input string tag);
    int w = 0;
    while (!req_ready[s] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_wait"}, 64'(req_ready[s]), 64'd1);
  endtask

  // One request with an optional PAUSE burst starting at shift index pstart.
  task automatic do_load(input int s, input logic [63:0] data,
                         input int pstart, input int plen,
                         input logic [63:0] exp_rd, input string tag);
    int l;
    int shifts, pused, ces, dones;
    int bad_ce, bad_busy, bad_rdy, bad_done;
    logic exp_busy, exp_ce, exp_done, exp_rdy;
    logic [63:0] rd_at_done;
    l = len(s);
    shifts = 0; pused = 0; ces = 0; dones = 0;
    bad_ce = 0; bad_busy = 0; bad_rdy = 0; bad_done = 0;
    rd_at_done = '1;
    wait_ready(s, tag);
    req_valid[s] = 1'b1;
    req_data[s]  = data & msk(s);
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_data[s]  = {$urandom, $urandom};
    for (int k = 1; k <= l + plen + 2; k++) begin
      pause[s] = (shifts == pstart) && (pused < plen);
      if (pause[s]) pused++;
      #1;
      exp_busy = (k <= l + plen);
      exp_ce   = exp_busy && !pause[s];
      exp_done = (k == l + plen + 1);
      exp_rdy  = (k == l + plen + 2);
      if (ce[s] !== exp_ce) bad_ce++;
      if (busy[s] !== exp_busy) bad_busy++;
      if (done[s] !== exp_done) bad_done++;
      if (req_ready[s] !== exp_rdy) bad_rdy++;
      if (ce[s] === 1'b1) begin
        ces++;
        shifts++;
      end
      if (done[s] === 1'b1) begin
        dones++;
        rd_at_done = rdbk(s);
      end
      @(negedge clk);
    end
    pause[s] = 1'b0;
    check({tag, " ce_cycles"}, 64'(ces), 64'(l));
    check({tag, " done_pulses"}, 64'(dones), 64'd1);
    check({tag, " ce_pattern_errs"}, 64'(bad_ce), 64'd0);
    check({tag, " busy_errs"}, 64'(bad_busy), 64'd0);
    check({tag, " done_timing_errs"}, 64'(bad_done), 64'd0);
    check({tag, " ready_errs"}, 64'(bad_rdy), 64'd0);
    check({tag, " rdbk_at_done"}, rd_at_done, exp_rd);
    check({tag, " rdbk_held"}, rdbk(s), exp_rd);
    check({tag, " lut_contents"}, chain(s), data & msk(s));
    exp_chain[s] = data & msk(s);
  endtask

  // REQ_VALID held high: accepts must be exactly L+2 cycles apart.
  task automatic back_to_back(input int s, input logic [63:0] data);
    int l;
    int acc [$];
    int k, ces, w;
    logic dn;
    logic [63:0] rd;
    l = len(s);
    ces = 0; k = 0; dn = 1'b0; w = 0; rd = '0;
    wait_ready(s, "b2b");
    req_valid[s] = 1'b1;
    req_data[s]  = data & msk(s);
    while (acc.size() < 3 && k < 1000) begin
      #1;
      if (req_ready[s] === 1'b1) acc.push_back(k);
      if (ce[s] === 1'b1) ces++;
      @(negedge clk);
      k++;
    end
    req_valid[s] = 1'b0;
    while (!dn && w < 200) begin
      #1;
      if (ce[s] === 1'b1) ces++;
      if (done[s] === 1'b1) begin
        dn = 1'b1;
        rd = rdbk(s);
      end
      @(negedge clk);
      w++;
    end
    check("b2b accepts", 64'(acc.size()), 64'd3);
    if (acc.size() == 3) begin
      check("b2b spacing1", 64'(acc[1] - acc[0]), 64'(l + 2));
      check("b2b spacing2", 64'(acc[2] - acc[1]), 64'(l + 2));
    end
    check("b2b ce_cycles", 64'(ces), 64'(3 * l));
    check("b2b done_seen", 64'(dn), 64'd1);
    check("b2b rdbk", rd, data & msk(s));
    check("b2b lut_contents", chain(s), data & msk(s));
    exp_chain[s] = data & msk(s);
  endtask

  // Reset after 16 shifts: chain keeps the partially shifted image.
  task automatic reset_mid(input int s, input logic [63:0] data);
    int l, shifts, w, bad;
    logic sawdone;
    l = len(s);
    shifts = 0; w = 0; bad = 0; sawdone = 1'b0;
    wait_ready(s, "rst");
    req_valid[s] = 1'b1;
    req_data[s]  = data & msk(s);
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    while (shifts < 16 && w < 100) begin
      #1;
      if (ce[s] === 1'b1) shifts++;
      if (done[s] === 1'b1) sawdone = 1'b1;
      @(negedge clk);
      w++;
    end
    check("rst shifts_before", 64'(shifts), 64'd16);
    rstn = 1'b0;
    #1;
    check("rst ce_async", 64'(ce[s]), 64'd0);
    check("rst ready_async", 64'(req_ready[s]), 64'd1);
    check("rst busy_async", 64'(busy[s]), 64'd0);
    check("rst rdbk_cleared", rdbk(s), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done[s] === 1'b1) sawdone = 1'b1;
      if (req_ready[s] !== 1'b1 || ce[s] !== 1'b0) bad++;
      @(negedge clk);
    end
    check("rst no_done", 64'(sawdone), 64'd0);
    check("rst idle_after", 64'(bad), 64'd0);
    exp_chain[s] = ((exp_chain[s] << 16) |
                    ((data & msk(s)) >> (l - 16))) & msk(s);
    check("rst partial_contents", chain(s), exp_chain[s]);
  endtask

  typedef struct {
    int          s;
    logic [63:0] data;
    int          pstart;
    int          plen;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{0, 64'h0000_0000_DEAD_BEEF, 0, 0, 64'h0};
    tbl[1] = '{0, 64'h0000_0000_1234_5678, 0, 0, 64'h0000_0000_DEAD_BEEF};
    tbl[2] = '{1, 64'hAAAA_5555_0F0F_F0F0, 0, 0, 64'h0};
    tbl[3] = '{1, 64'hAAAA_5555_0F0F_F0F0, 0, 0, 64'hAAAA_5555_0F0F_F0F0};
    tbl[4] = '{0, 64'h0000_0000_DEAD_BEEF, 10, 5, 64'h0000_0000_1234_5678};

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      pause[s]     = 1'b0;
      req_data[s]  = '0;
      exp_chain[s] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset ready", 64'(req_ready[s]), 64'd1);
      check("reset ce", 64'(ce[s]), 64'd0);
      check("reset cdi", 64'(cdi[s]), 64'd0);
      check("reset busy", 64'(busy[s]), 64'd0);
      check("reset done", 64'(done[s]), 64'd0);
      check("reset rdbk", rdbk(s), 64'd0);
    end
    // PAUSE outside SHIFT must not matter.
    pause[0] = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("idle pause ce", 64'(ce[0]), 64'd0);
    check("idle pause ready", 64'(req_ready[0]), 64'd1);
    pause[0] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_load(tbl[i].s, tbl[i].data, tbl[i].pstart, tbl[i].plen,
              tbl[i].exp_rd, $sformatf("vec%0d", i));
      if (i == 1) check("o6 addr0", 64'(lut0[0]), 64'd0);
    end

    back_to_back(1, {$urandom, $urandom});
    back_to_back(0, {$urandom, $urandom});

    reset_mid(0, {$urandom, $urandom});
    do_load(0, {$urandom, $urandom}, 40, 0, exp_chain[0], "post_rst");
    reset_mid(1, {$urandom, $urandom});
    do_load(1, {$urandom, $urandom}, 100, 0, exp_chain[1], "post_rst1");

    for (int i = 0; i < 8; i++) begin
      int s, ps, pl;
      s  = int'($urandom_range(0, 1));
      ps = int'($urandom_range(0, len(s) - 1));
      pl = int'($urandom_range(0, 6));
      do_load(s, {$urandom, $urandom}, ps, pl, exp_chain[s],
              $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfglut5_reconfig_ctrl.md
Name: cfglut5_reconfig_ctrl

Overview:
- Serial reconfiguration sequencer for a chain of NUM_LUTS CFGLUT5 primitives. The chain is cascaded: controller CDI drives the head LUT, each CDO feeds the next LUT's CDI, and the tail LUT's CDO returns to the controller.
- Accepts a full chain configuration word over a valid/ready handshake and shifts it in MSB-first with CE gating.
- Captures the displaced old contents from the tail CDO as readback.
- Sits between the configuration register interface and the reconfigurable LUT fabric.

Parameters:
- NUM_LUTS, 1, number of cascaded CFGLUT5s; total shift length L = 32*NUM_LUTS.

Ports:
- CLK  input  1  rising-edge clock, shared with the LUT chain.
- RSTN  input  1  asynchronous active-low reset.
- REQ_VALID  input  1  configuration request valid.
- REQ_READY  output  1  controller can accept a request.
- REQ_DATA  input  L  new chain contents. REQ_DATA[L-1 -: 32] is the tail LUT INIT; REQ_DATA[31:0] is the head LUT INIT.
- PAUSE  input  1  stalls shifting while high; state and counters hold.
- LUT_CE  output  1  chain CE.
- LUT_CDI  output  1  chain head CDI.
- LUT_CDO  input  1  tail LUT CDO.
- BUSY  output  1  high in SHIFT.
- DONE  output  1  one-cycle pulse when the load is complete.
- RDBK_DATA  output  L  previous chain contents, same packing as REQ_DATA.

Behaviour:
- Reset (async, RSTN=0): state=IDLE, REQ_READY=1, LUT_CE=0, LUT_CDI=0, BUSY=0, DONE=0, RDBK_DATA=0, counter=0, shift register=0. LUT contents are not touched by reset.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - REQ_READY=1.
  - On a clock edge with REQ_VALID=1, load the shift register with REQ_DATA, set counter=0, go to SHIFT.
  - REQ_DATA is sampled only at the accepting edge.
- SHIFT:
  - REQ_READY=0, BUSY=1.
  - LUT_CE = ~PAUSE, driven combinationally from state and PAUSE.
  - LUT_CDI = shift register MSB.
  - On each edge with PAUSE=0:
    - shift register shifts left, filling 0;
    - RDBK capture register shifts left, taking LUT_CDO into its LSB. LUT_CDO is sampled before the edge, so it is the old tail r[31];
    - counter increments.
  - When the counter reaches L-1 and a shift occurs, go to FINISH.
  - Exactly L CE-high cycles per request, never more.
  - PAUSE=1: LUT_CE=0, nothing advances. PAUSE has effect only in SHIFT.
- FINISH:
  - Exactly one cycle.
  - DONE=1, RDBK_DATA updated with the capture register. RDBK_DATA is held until the next FINISH.
  - REQ_READY=0, LUT_CE=0. Next state is IDLE.
- Data ordering:
  - Bit L-1 is shifted first, so after L shifts the tail LUT r equals REQ_DATA[L-1 -: 32] and the head LUT r equals REQ_DATA[31:0].
  - RDBK_DATA uses the same packing, giving a bit-exact round-trip.
- Latency, with no PAUSE:
  - Accept at edge T.
  - CE high during cycles T+1 .. T+L.
  - DONE high in cycle T+L+1.
  - REQ_READY high again in cycle T+L+2.
  - Minimum request-to-request spacing is L+2 cycles.
- REQ_VALID while not ready: ignored. The requester must hold the request until the handshake.
- REQ_VALID high in the DONE cycle: not accepted until the next cycle (IDLE).
- Reset mid-SHIFT: immediately IDLE and LUT_CE=0. Partially shifted LUT contents are undefined; no DONE pulse is issued. RDBK_DATA is cleared to 0.
- Counter width: $clog2(L) bits, or 1 bit minimum. The counter does not wrap within a load.

Test Plan:
- NUM_LUTS=1, LUT model INIT=32'h0000_0000, REQ_DATA=32'hDEAD_BEEF, PAUSE=0 -> 32 consecutive CE cycles, DONE in cycle 33 after accept, LUT r=32'hDEADBEEF, RDBK_DATA=32'h0.
- Second load of 32'h1234_5678 on the same LUT -> LUT r=32'h12345678, RDBK_DATA=32'hDEADBEEF; O6 at address 5'h00 equals bit 0 = 0.
- NUM_LUTS=2, REQ_DATA=64'hAAAA_5555_0F0F_F0F0 -> 64 CE cycles; tail r=32'hAAAA5555, head r=32'h0F0FF0F0; a repeat load returns identical RDBK_DATA.
- PAUSE high for 5 cycles starting at shift 10 -> CE low for exactly those 5 cycles, 32 CE cycles total, DONE delayed by 5 cycles, final contents unchanged from the no-pause case.
- REQ_VALID held high continuously -> accepts spaced exactly L+2 cycles apart; REQ_READY=0 throughout SHIFT and FINISH.
- RSTN pulsed low at shift 16 -> LUT_CE=0 asynchronously, no DONE, REQ_READY=1 after release, RDBK_DATA=0. A subsequent full load completes normally.
